// File: rtl/dec_align_shift.sv
// dec_align_shift: iterative decimal significand aligner.
// Routes the larger-exponent operand to Ml unshifted and shifts the other one
// right by one BCD digit per clock, collecting guard/round/sticky digits.
module dec_align_shift #(
  parameter int NDIG  = 7,
  parameter int EW    = 8,
  parameter int MAXSH = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] Ma,
  input  logic [EW-1:0]     Ea,
  input  logic [4*NDIG-1:0] Mb,
  input  logic [EW-1:0]     Eb,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] Ml,
  output logic [4*NDIG-1:0] Ms,
  output logic [EW-1:0]     E_res,
  output logic [11:0]       GRS,
  output logic              swap
);

  localparam int W  = 4 * NDIG;
  localparam int CW = $clog2(MAXSH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  ml_q, ml_d;
  logic [W-1:0]  ms_q, ms_d;
  logic [EW-1:0] e_res_q, e_res_d;
  logic [11:0]   grs_q, grs_d;
  logic          swap_q, swap_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Exponent difference is formed one bit wider than the exponents so it never wraps.
  logic          a_ge_b;
  logic [EW:0]   diff;
  logic [CW-1:0] shamt;

  // Operand ordering and clamped shift amount for the pair on the inputs.
  always_comb begin
    a_ge_b = (Ea >= Eb);
    diff   = a_ge_b ? ({1'b0, Ea} - {1'b0, Eb}) : ({1'b0, Eb} - {1'b0, Ea});
    shamt  = (diff >= (EW+1)'(MAXSH)) ? CW'(MAXSH) : diff[CW-1:0];
  end

  // Next-state and datapath updates; every register holds unless its state moves it.
  always_comb begin
    state_d = state_q;
    ml_d    = ml_q;
    ms_d    = ms_q;
    e_res_d = e_res_q;
    grs_d   = grs_q;
    swap_d  = swap_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          swap_d  = ~a_ge_b;
          ml_d    = a_ge_b ? Ma : Mb;
          ms_d    = a_ge_b ? Mb : Ma;
          e_res_d = a_ge_b ? Ea : Eb;
          grs_d   = 12'h000;
          cnt_d   = shamt;
          state_d = (shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        // Digit falling off Ms becomes guard; old guard becomes round; old round folds into sticky.
        grs_d   = {ms_q[3:0], grs_q[11:8], 3'b000, grs_q[0] | (grs_q[7:4] != 4'h0)};
        ms_d    = {4'h0, ms_q[W-1:4]};
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any in-flight pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ml_q    <= '0;
      ms_q    <= '0;
      e_res_q <= '0;
      grs_q   <= '0;
      swap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ml_q    <= ml_d;
      ms_q    <= ms_d;
      e_res_q <= e_res_d;
      grs_q   <= grs_d;
      swap_q  <= swap_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign Ml        = ml_q;
  assign Ms        = ms_q;
  assign E_res     = e_res_q;
  assign GRS       = grs_q;
  assign swap      = swap_q;

endmodule

// File: tb/tb_dec_align_shift.sv
// tb_dec_align_shift: directed vectors with hand-computed results for dec_align_shift.
module tb_dec_align_shift;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [27:0] Ma, Mb;
  logic [7:0]  Ea, Eb;
  logic        out_valid;
  logic        out_ready;
  logic [27:0] Ml, Ms;
  logic [7:0]  E_res;
  logic [11:0] GRS;
  logic        swap;

  int total = 0;
  int bad   = 0;

  dec_align_shift dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .Ma(Ma), .Ea(Ea), .Mb(Mb), .Eb(Eb),
    .out_valid(out_valid), .out_ready(out_ready),
    .Ml(Ml), .Ms(Ms), .E_res(E_res), .GRS(GRS), .swap(swap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a pair at posedge+1, accept it on the next edge, then wait for out_valid.
  // lat counts the accept edge as clock 1.
  task automatic send(input logic [27:0] a, input logic [7:0] ea,
                      input logic [27:0] b, input logic [7:0] eb, output int lat);
    Ma = a; Ea = ea; Mb = b; Eb = eb; in_valid = 1'b1;
    chk("in_ready_before_accept", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) chk("out_valid_timeout", out_valid, 1'b1);
  endtask

  task automatic expect_res(input string tag, input logic sw, input logic [27:0] ml,
                            input logic [27:0] ms, input logic [11:0] grs,
                            input logic [7:0] er, input int lat, input int exp_lat);
    chk({tag, "_swap"}, swap, sw);
    chk({tag, "_Ml"}, Ml, ml);
    chk({tag, "_Ms"}, Ms, ms);
    chk({tag, "_GRS"}, GRS, grs);
    chk({tag, "_E_res"}, E_res, er);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_in_ready_done"}, in_ready, 1'b0);
    $display("%s: swap=%0d Ml=%07h Ms=%07h GRS=%03h E_res=%02h lat=%0d",
             tag, swap, Ml, Ms, GRS, E_res, lat);
  endtask

  task automatic finish_hs(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_out_valid_fall"}, out_valid, 1'b0);
    chk({tag, "_in_ready_idle"}, in_ready, 1'b1);
  endtask

  initial begin
    int lat;
    logic [27:0] ml_hold, ms_hold;
    logic [11:0] grs_hold;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    Ma = '0; Mb = '0; Ea = '0; Eb = '0;
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_Ml", Ml, 28'h0);
    chk("rst_Ms", Ms, 28'h0);
    chk("rst_GRS", GRS, 12'h0);
    chk("rst_E_res", E_res, 8'h0);
    chk("rst_swap", swap, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_ready", in_ready, 1'b1);

    // Case 1: d=2, no swap
    send(28'h1234567, 8'h65, 28'h7654321, 8'h63, lat);
    expect_res("c1", 1'b0, 28'h1234567, 28'h0076543, 12'h210, 8'h65, lat, 3);
    finish_hs("c1");

    // Case 2: d=2, swap
    send(28'h0000005, 8'h10, 28'h9999999, 8'h12, lat);
    expect_res("c2", 1'b1, 28'h9999999, 28'h0000000, 12'h050, 8'h12, lat, 3);
    finish_hs("c2");

    // Case 3: equal exponents
    send(28'h1111111, 8'h40, 28'h2345678, 8'h40, lat);
    expect_res("c3", 1'b0, 28'h1111111, 28'h2345678, 12'h000, 8'h40, lat, 1);
    finish_hs("c3");

    // Case 4: clamp at 10 shifts, sticky from nonzero then zero
    send(28'h3333333, 8'h50, 28'h0000001, 8'h28, lat);
    expect_res("c4a", 1'b0, 28'h3333333, 28'h0000000, 12'h001, 8'h50, lat, 11);
    finish_hs("c4a");
    send(28'h3333333, 8'h50, 28'h0000000, 8'h28, lat);
    expect_res("c4b", 1'b0, 28'h3333333, 28'h0000000, 12'h000, 8'h50, lat, 11);
    finish_hs("c4b");

    // Extra: d=3 swap, round digit nonzero feeds sticky
    send(28'h1234567, 8'h00, 28'h7000000, 8'h03, lat);
    expect_res("cx", 1'b1, 28'h7000000, 28'h0001234, 12'h561, 8'h03, lat, 4);
    finish_hs("cx");

    // Extra: extreme exponents, no wrap
    send(28'h0000009, 8'h00, 28'h5555555, 8'hFF, lat);
    expect_res("cw", 1'b1, 28'h5555555, 28'h0000000, 12'h001, 8'hFF, lat, 11);
    finish_hs("cw");

    // Case 5: backpressure in DONE with in_valid asserted
    send(28'h1234567, 8'h65, 28'h7654321, 8'h63, lat);
    ml_hold = Ml; ms_hold = Ms; grs_hold = GRS;
    Ma = 28'h9876543; Ea = 8'h01; Mb = 28'h1111111; Eb = 8'h02; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("c5_hold_out_valid", out_valid, 1'b1);
      chk("c5_hold_in_ready", in_ready, 1'b0);
      chk("c5_hold_Ml", Ml, ml_hold);
      chk("c5_hold_Ms", Ms, ms_hold);
      chk("c5_hold_GRS", GRS, grs_hold);
    end
    $display("c5: held 5 clk Ml=%07h Ms=%07h GRS=%03h", Ml, Ms, GRS);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("c5_out_valid_fall", out_valid, 1'b0);
    chk("c5_in_ready_idle", in_ready, 1'b1);
    chk("c5_no_capture_Ml", Ml, 28'h1234567);
    lat = 1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    // Ea=01, Eb=02 -> swap, Ms=9876543>>1 digit = 0987654, guard=3
    expect_res("c5_next", 1'b1, 28'h1111111, 28'h0987654, 12'h300, 8'h02, lat, 2);
    finish_hs("c5_next");

    // Case 6: reset during the 3rd SHIFT cycle of case 4
    Ma = 28'h3333333; Ea = 8'h50; Mb = 28'h0000001; Eb = 8'h28; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("c6_rst_in_ready", in_ready, 1'b0);
    chk("c6_rst_out_valid", out_valid, 1'b0);
    chk("c6_rst_Ml", Ml, 28'h0);
    chk("c6_rst_Ms", Ms, 28'h0);
    chk("c6_rst_GRS", GRS, 12'h0);
    chk("c6_rst_E_res", E_res, 8'h0);
    chk("c6_rst_swap", swap, 1'b0);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("c6_idle_in_ready", in_ready, 1'b1);
    chk("c6_idle_out_valid", out_valid, 1'b0);
    $display("c6: reset abort, in_ready=%0d out_valid=%0d", in_ready, out_valid);
    send(28'h1234567, 8'h65, 28'h7654321, 8'h63, lat);
    expect_res("c6_c1", 1'b0, 28'h1234567, 28'h0076543, 12'h210, 8'h65, lat, 3);
    finish_hs("c6_c1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
